// File: rtl/lag_pl_out_allocator.sv
// Per-output-port PL allocator: round-robin pick of one requesting input PL and
// assignment of one free downstream PL. Optional macro LAG_PL_ALLOC_RR_PL_SELECT_EN
// makes PL selection round-robin too (pl_ptr); default picks the lowest free PL.
module lag_pl_out_allocator #(
  parameter int unsigned num_inputs     = 5,
  parameter int unsigned num_pls_global = 4,
  parameter int unsigned num_pls_local  = 4,
  parameter int unsigned pl_id_w        = (num_pls_global > 1) ? $clog2(num_pls_global) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [num_inputs-1:0]     req,
  input  logic [num_pls_global-1:0] pl_alloc_status,
  output logic [num_pls_global-1:0] pl_allocated,
  output logic [num_inputs-1:0]     grant,
  output logic [pl_id_w-1:0]        grant_pl_id,
  output logic                      alloc_valid
);

  localparam int unsigned RR_W = (num_inputs > 1) ? $clog2(num_inputs) : 1;

  logic [num_inputs-1:0]     grant_q, grant_d;
  logic [num_pls_global-1:0] pl_alloc_q, pl_alloc_d;
  logic [pl_id_w-1:0]        pl_id_q, pl_id_d;
  logic [RR_W-1:0]           rr_ptr_q, rr_ptr_d;

  logic [num_pls_global-1:0] local_mask;
  logic [num_pls_global-1:0] avail;
  logic [num_inputs-1:0]     eff_req;
  logic [2*num_inputs-1:0]   req_rot;
  logic                      win_found;
  logic [RR_W-1:0]           win_idx;
  logic                      pl_found;
  logic [pl_id_w-1:0]        pl_idx;
  logic                      alloc;
  int unsigned               win_sum;

`ifdef LAG_PL_ALLOC_RR_PL_SELECT_EN
  logic [pl_id_w-1:0]         pl_ptr_q, pl_ptr_d;
  logic [2*num_pls_local-1:0] avail_rot;
  int unsigned                pl_sum;
`endif

  always_comb begin
    local_mask = '0;
    for (int unsigned k = 0; k < num_pls_global; k++) begin
      local_mask[k] = (k < num_pls_local);
    end
  end

  // The PL pulsed last cycle is still marked free by the pool, so mask it here.
  assign avail   = pl_alloc_status & ~pl_alloc_q & local_mask;
  assign eff_req = req & ~grant_q;

  always_comb begin
    req_rot   = {eff_req, eff_req} >> rr_ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = 0;
    for (int unsigned k = 0; k < num_inputs; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_sum   = 32'(rr_ptr_q) + k;
        if (win_sum >= num_inputs) win_sum = win_sum - num_inputs;
        win_idx   = RR_W'(win_sum);
      end
    end
  end

`ifdef LAG_PL_ALLOC_RR_PL_SELECT_EN
  always_comb begin
    avail_rot = {avail[num_pls_local-1:0], avail[num_pls_local-1:0]} >> pl_ptr_q;
    pl_found  = 1'b0;
    pl_idx    = '0;
    pl_sum    = 0;
    for (int unsigned k = 0; k < num_pls_local; k++) begin
      if (!pl_found && avail_rot[k]) begin
        pl_found = 1'b1;
        pl_sum   = 32'(pl_ptr_q) + k;
        if (pl_sum >= num_pls_local) pl_sum = pl_sum - num_pls_local;
        pl_idx   = pl_id_w'(pl_sum);
      end
    end
  end
`else
  always_comb begin
    pl_found = 1'b0;
    pl_idx   = '0;
    for (int unsigned k = 0; k < num_pls_global; k++) begin
      if (!pl_found && avail[k]) begin
        pl_found = 1'b1;
        pl_idx   = pl_id_w'(k);
      end
    end
  end
`endif

  assign alloc = win_found && pl_found;

  always_comb begin
    grant_d    = '0;
    pl_alloc_d = '0;
    pl_id_d    = '0;
    rr_ptr_d   = rr_ptr_q;
    if (alloc) begin
      grant_d[win_idx]   = 1'b1;
      pl_alloc_d[pl_idx] = 1'b1;
      pl_id_d            = pl_idx;
      rr_ptr_d           = (32'(win_idx) == num_inputs - 1) ? '0 : RR_W'(32'(win_idx) + 1);
    end
  end

`ifdef LAG_PL_ALLOC_RR_PL_SELECT_EN
  always_comb begin
    pl_ptr_d = pl_ptr_q;
    if (alloc) begin
      pl_ptr_d = (32'(pl_idx) == num_pls_local - 1) ? '0 : pl_id_w'(32'(pl_idx) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pl_ptr_q <= '0;
    else        pl_ptr_q <= pl_ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q    <= '0;
      pl_alloc_q <= '0;
      pl_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      grant_q    <= grant_d;
      pl_alloc_q <= pl_alloc_d;
      pl_id_q    <= pl_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant        = grant_q;
  assign pl_allocated = pl_alloc_q;
  assign grant_pl_id  = pl_id_q;
  assign alloc_valid  = |grant_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(grant_q))
        else $error("grant not one-hot: %b", grant_q);
      if (|pl_alloc_q) begin
        assert ((pl_alloc_q & ~pl_alloc_status) == '0)
          else $error("allocated PL not free: alloc=%b status=%b", pl_alloc_q, pl_alloc_status);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lag_pl_out_allocator.sv
// Directed bench for lag_pl_out_allocator: a main instance (4 local PLs) and a
// second instance with only 2 local PLs that must never grant upper PLs.
module tb_lag_pl_out_allocator;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic [3:0] status;
  logic [3:0] pl_allocated;
  logic [4:0] grant;
  logic [1:0] grant_pl_id;
  logic       alloc_valid;

  logic [4:0] req2;
  logic [3:0] status2;
  logic [3:0] pl_allocated2;
  logic [4:0] grant2;
  logic [1:0] grant_pl_id2;
  logic       alloc_valid2;

  logic       pool_en;
  int         tests;
  int         fails;
  int         fair_id [6];
  int         seq_id  [5];

  lag_pl_out_allocator #(
    .num_inputs(5), .num_pls_global(4), .num_pls_local(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pl_alloc_status(status),
    .pl_allocated(pl_allocated), .grant(grant), .grant_pl_id(grant_pl_id),
    .alloc_valid(alloc_valid)
  );

  lag_pl_out_allocator #(
    .num_inputs(5), .num_pls_global(4), .num_pls_local(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .pl_alloc_status(status2),
    .pl_allocated(pl_allocated2), .grant(grant2), .grant_pl_id(grant_pl_id2),
    .alloc_valid(alloc_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-pool model: a PL pulsed during a cycle is cleared only at the end of it.
  task automatic tick();
    logic [3:0] prev;
    prev = pl_allocated;
    @(posedge clk);
    #1;
    if (pool_en) status = status & ~prev;
  endtask

  task automatic expect_grant(input string tag, input logic [4:0] g, input int id);
    logic [11:0] obs;
    logic [11:0] exp;
    logic [3:0]  pa;
    pa  = (g != 5'b0) ? (4'b0001 << id) : 4'b0000;
    obs = {grant, pl_allocated, grant_pl_id, alloc_valid};
    exp = {g, pa, (g != 5'b0) ? 2'(id) : 2'b00, |g};
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic expect_idle2(input string tag);
    logic [9:0] obs;
    obs = {grant2, pl_allocated2, alloc_valid2};
    tests++;
    assert (obs === 10'b0)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, 10'b0);
      end
  endtask

  initial begin
    tests = 0;
    fails = 0;
`ifdef LAG_PL_ALLOC_RR_PL_SELECT_EN
    fair_id = '{0, 1, 2, 3, 0, 1};
    seq_id  = '{0, 1, 2, 3, 0};
`else
    fair_id = '{0, 1, 0, 1, 0, 1};
    seq_id  = '{0, 0, 0, 0, 0};
`endif
    rst_n   = 1'b0;
    req     = 5'b11111;
    status  = 4'b1111;
    req2    = 5'b11111;
    status2 = 4'b1100;
    pool_en = 1'b0;

    tick(); expect_grant("reset_c0", 5'b00000, 0);
    tick(); expect_grant("reset_c1", 5'b00000, 0);
    rst_n = 1'b1;

    // Fairness: all requesting, status held full.
    for (int n = 0; n < 6; n++) begin
      tick();
      expect_grant($sformatf("fair_%0d", n), 5'b00001 << (n % 5), fair_id[n]);
      expect_idle2($sformatf("local2_%0d", n));
    end

    // Mid-operation reset discards the in-flight state.
    rst_n = 1'b0;
    tick(); expect_grant("midrst", 5'b00000, 0);

    // PL exhaustion with the free-pool lag model.
    rst_n   = 1'b1;
    req     = 5'b00111;
    status  = 4'b0011;
    pool_en = 1'b1;
    tick(); expect_grant("exh_in0_pl0", 5'b00001, 0);
    tick(); expect_grant("exh_in1_pl1", 5'b00010, 1);
    tick(); expect_grant("exh_empty0", 5'b00000, 0);
    tick(); expect_grant("exh_empty1", 5'b00000, 0);
    status = status | 4'b0100;
    tick(); expect_grant("exh_refill_in2", 5'b00100, 2);
    req = 5'b00000;
    tick(); expect_grant("noreq", 5'b00000, 0);

    // Back-to-back mask: PL0 stays marked free during its pulse cycle.
    status = 4'b0001;
    req    = 5'b00011;
    tick(); expect_grant("b2b_first", 5'b00001, 0);
    tick(); expect_grant("b2b_masked", 5'b00000, 0);
    tick(); expect_grant("b2b_empty", 5'b00000, 0);
    req = 5'b00000;

    // Single continuous requester: PL id sequence over successive grants.
    rst_n = 1'b0;
    tick(); expect_grant("rst2", 5'b00000, 0);
    rst_n   = 1'b1;
    pool_en = 1'b0;
    status  = 4'b1111;
    req     = 5'b00001;
    for (int n = 0; n < 5; n++) begin
      tick(); expect_grant($sformatf("seq_grant_%0d", n), 5'b00001, seq_id[n]);
      tick(); expect_grant($sformatf("seq_idle_%0d", n), 5'b00000, 0);
    end
    expect_idle2("local2_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lag_pl_out_allocator.md
Name: lag_pl_out_allocator

Overview:
- Per-output-port PL allocator that sits directly downstream of that port's PL free pool.
- Each cycle it picks at most one requesting input PL, round-robin, and assigns it one free downstream PL taken from the free pool's pl_alloc_status vector.
- It drives the one-cycle pl_allocated pulse back to the free pool.
- It returns a registered one-hot grant and the granted PL id to the requesting input.

Parameters:
- num_inputs, 5, number of requesters (input PLs) competing for this output port
- num_pls_global, 4, width of PL vectors in the router
- num_pls_local, 4, PLs actually present at this output; PL indices >= num_pls_local are never granted
- pl_id_w, $clog2(num_pls_global) (minimum 1), width of the binary PL id output

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  num_inputs  request vector; a requester holds its bit high until it sees its grant
- pl_alloc_status  in  num_pls_global  1 = PL free (from the free pool)
- pl_allocated  out  num_pls_global  one-hot pulse, PL consumed this cycle (to the free pool)
- grant  out  num_inputs  one-hot, registered, requester granted
- grant_pl_id  out  pl_id_w  binary id of the granted PL; valid only while |grant
- alloc_valid  out  1  equals |grant

Behaviour:
- Reset (rst_n low at a clk edge): grant, pl_allocated, grant_pl_id and alloc_valid are 0; round-robin pointer rr_ptr is 0.
- Reset asserted mid-operation discards any grant in flight; the next cycle shows all outputs 0.
- Decision logic, each cycle, combinational from registered state:
  - avail = pl_alloc_status & ~pl_allocated & local_mask, where local_mask has bits [num_pls_local-1:0] set.
  - Masking the PL granted last cycle is required: the free pool only clears that status bit at the end of the pulse cycle.
  - eff_req = req & ~grant. A requester granted last cycle is ignored for one cycle while it drops req.
  - If eff_req != 0 and avail != 0: winner = first set bit of eff_req searching upward from rr_ptr, wrapping modulo num_inputs. PL = lowest-index set bit of avail.
- Registering: at the clk edge, grant <= onehot(winner), pl_allocated <= onehot(PL), grant_pl_id <= PL, rr_ptr <= (winner+1) mod num_inputs.
  - Wrap case: if winner = num_inputs-1, rr_ptr becomes 0.
- Latency: a request arriving in cycle t is granted in cycle t+1 at the earliest. Every grant and pl_allocated pulse lasts exactly one cycle.
- No free PL (avail = 0): no grant, all outputs 0 next cycle, rr_ptr unchanged. Requests are held, not dropped.
- No requests: outputs 0, rr_ptr unchanged.
- At most one grant and one PL per cycle. pl_allocated and grant are always both zero or both one-hot.
- PL freed and allocated in the same cycle: if a pl_alloc_status bit rises in cycle t, it is eligible in cycle t, subject to the pl_allocated mask.
- Starvation-free: a continuously asserted request is granted within num_inputs successful allocations.
- Simulation assertions:
  - grant is one-hot or zero.
  - pl_allocated & ~pl_alloc_status == 0 whenever pl_allocated is nonzero.

Optional Feature:
- Macro LAG_PL_ALLOC_RR_PL_SELECT_EN.
- Defined: PL selection also round-robins. A second pointer pl_ptr (reset 0) searches avail upward with wrap; it updates to (PL+1) mod num_pls_local on each allocation. This spreads load across downstream buffers.
- Undefined: lowest-index free PL, as above; pl_ptr is not instantiated.
- Requester arbitration is identical in both builds.

Test Plan:
- Reset check: rst_n=0 for 2 cycles with req=5'b11111, status=4'b1111 -> all outputs 0 during reset; first grant after release is grant=5'b00001 with pl_allocated=4'b0001, id 0.
- Fairness: req=5'b11111 held, status held 4'b1111 (free pool model re-frees PLs) -> grants rotate 00001,00010,00100,01000,10000, then wrap to 00001. Each grant is followed by one idle cycle for that requester only.
- PL exhaustion: status=4'b0011, no refill, req=5'b00111 -> input0 gets PL0, next cycle input1 gets PL1 (PL0 masked), then no grant while status=0. Refill PL2 via status bit -> input2 granted id 2 the following cycle.
- Back-to-back mask: status stays 4'b0001 for one cycle after the pulse (model free pool lag), req=5'b00011 -> PL0 granted once, never twice consecutively.
- num_pls_local=2, num_pls_global=4, status=4'b1100 -> no grant ever.
- With LAG_PL_ALLOC_RR_PL_SELECT_EN, status always 4'b1111, req=5'b00001 continuous -> grant_pl_id sequence 0,1,2,3,0 on successive grants. Without the macro the sequence is 0,0,0,0.
